// File: rtl/mcpu_pkg.sv
// Shared MCPU constants and types used by the fetch stage and its IF/ID register.
package mcpu_pkg;

  localparam int              PC_W        = 10;
  localparam logic [PC_W-1:0] RESET_PC    = 10'h000;
  localparam logic [31:0]     NOP_INSTR   = 32'h0000_0000;
  localparam int              INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage control, instruction-memory and IF/ID signals.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_fetch_stage_if;
  import mcpu_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_target;
  logic            halt_req;
  logic [31:0]     im_instr;
  logic [PC_W-1:0] pc_out;
  logic [31:0]     ifid_instr;
  logic [PC_W-1:0] ifid_pc_plus4;
  logic            ifid_valid;
  logic            halted;
  logic            misalign_err;

  modport master (
    input  stall, redirect_valid, redirect_target, halt_req, im_instr,
    output pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, halted, misalign_err
  );

  modport slave (
    output stall, redirect_valid, redirect_target, halt_req, im_instr,
    input  pc_out, ifid_instr, ifid_pc_plus4, ifid_valid, halted, misalign_err
  );

endinterface

// File: rtl/if_fetch_stage_ifid_reg.sv
// IF/ID pipeline register. A bubble wins over hold, and hold wins over load.
module ifid_reg
  import mcpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic            hold_i,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_plus4_i,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic            valid_o
);

  logic [31:0]     instr_q;
  logic [PC_W-1:0] pc_plus4_q;
  logic            valid_q;

  always_ff @(posedge clk) begin
    if (rst || bubble_i) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!hold_i && load_i) begin
      instr_q    <= instr_i;
      pc_plus4_q <= pc_plus4_i;
      valid_q    <= 1'b1;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MCPU instruction-fetch stage: PC register, BOOT/RUN/HALT sequencing and next-PC
// selection (halt > redirect > stall > sequential), feeding the IF/ID register.
module if_fetch_stage
  import mcpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  if_fetch_stage_if.master fif
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_plus4;
  logic            misalign_q, misalign_d;
  logic            halted_q;
  logic            ifid_load, ifid_bubble, ifid_hold;

  assign pc_plus4 = pc_q + PC_W'(INSTR_BYTES);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = misalign_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_hold   = 1'b0;
    case (state_q)
      BOOT: begin
        state_d     = RUN;
        ifid_bubble = 1'b1;
      end
      RUN: begin
        // A misaligned target flags the error even when halt wins the same edge.
        if (fif.redirect_valid && (fif.redirect_target[1:0] != 2'b00))
          misalign_d = 1'b1;
        if (fif.halt_req) begin
          state_d     = HALT;
          ifid_bubble = 1'b1;
        end else if (fif.redirect_valid) begin
          pc_d        = {fif.redirect_target[PC_W-1:2], 2'b00};
          ifid_bubble = 1'b1;
        end else if (fif.stall) begin
          ifid_hold = 1'b1;
        end else begin
          pc_d      = pc_plus4;
          ifid_load = 1'b1;
        end
      end
      HALT: begin
        ifid_bubble = 1'b1;
      end
      default: begin
        state_d     = BOOT;
        ifid_bubble = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      halted_q   <= (state_d == HALT);
    end
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .hold_i     (ifid_hold),
    .instr_i    (fif.im_instr),
    .pc_plus4_i (pc_plus4),
    .instr_o    (fif.ifid_instr),
    .pc_plus4_o (fif.ifid_pc_plus4),
    .valid_o    (fif.ifid_valid)
  );

  assign fif.pc_out       = pc_q;
  assign fif.halted       = halted_q;
  assign fif.misalign_err = misalign_q;

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the MCPU pipeline; sits directly upstream of the instruction memory and feeds the IF/ID boundary.
- Owns the PC register and drives the 10-bit byte address into the combinational instruction memory.
- Captures the returned 32-bit instruction, plus PC+4, into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, halt and misaligned-target detection.

Parameters:
- PC_W, 10, byte-address width of PC; instruction memory is 2^PC_W bytes.
- RESET_PC, 10'h000, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, bubble instruction placed in IF/ID.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- stall  input  1  hazard stall from decode; holds PC and IF/ID.
- redirect_valid  input  1  taken branch/jump from a later stage.
- redirect_target  input  PC_W  new fetch byte address.
- halt_req  input  1  enter halted state; released only by rst.
- im_instr  input  32  instruction returned by instruction memory for pc_out (combinational, same cycle).
- pc_out  output  PC_W  current fetch address to instruction memory.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc_plus4  output  PC_W  IF/ID PC+4 of the captured instruction.
- ifid_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch is in the HALT state.
- misalign_err  output  1  sticky: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (rst=1 at an edge, any state, mid-stall or mid-redirect included):
  - pc_out=RESET_PC, ifid_instr=NOP_INSTR, ifid_pc_plus4=0, ifid_valid=0, halted=0, misalign_err=0, state=BOOT.
- FSM states: BOOT, RUN, HALT.
  - BOOT -> RUN unconditionally on the next edge. In BOOT the PC does not advance and IF/ID loads a bubble; this guarantees one clean cycle after reset.
  - RUN -> HALT when halt_req=1. halt_req takes priority over redirect and stall.
  - HALT is terminal until rst.
- HALT:
  - PC frozen.
  - IF/ID is loaded with a bubble on the entry edge and held there (ifid_valid=0).
  - halted=1.
- RUN next-PC priority, highest first: halt_req, redirect_valid, stall, sequential.
  - redirect_valid=1:
    - PC <= {redirect_target[PC_W-1:2], 2'b00}.
    - IF/ID <= bubble (flushes the wrong-path instruction).
    - Redirect overrides a simultaneous stall.
  - stall=1 (no redirect): PC and all IF/ID outputs hold their values.
  - Otherwise (sequential):
    - PC <= PC+4, modulo 2^PC_W; 10'h3FC wraps to 10'h000 with no error.
    - ifid_instr <= im_instr, ifid_pc_plus4 <= PC+4 (same modulo), ifid_valid <= 1.
- misalign_err:
  - Set on any RUN-state edge where redirect_valid=1 and redirect_target[1:0]!=0.
  - Stays set until rst; the target is still aligned down and taken.
- Latency:
  - pc_out is registered. The instruction for pc_out appears on ifid_instr one edge later.
  - A redirect accepted at edge N gives pc_out=target after N; that instruction is in IF/ID after N+1.
- Ports and widths:
  - Inputs are sampled only at rising edges; all outputs are register-driven (no combinational input-to-output paths).
  - All PC arithmetic is PC_W bits unsigned; carry is discarded.

Decomposition:
- Shared package mcpu_pkg:
  - PC_W, RESET_PC, NOP_INSTR.
  - fetch_state_t enum {BOOT, RUN, HALT}.
  - INSTR_BYTES=4.
- One natural sub-module: ifid_reg.
  - Holds the IF/ID register.
  - Inputs: load, bubble, hold.
  - Priority: bubble > hold > load.
- if_fetch_stage contains the PC register, FSM and next-PC mux, and instantiates ifid_reg.

Test Plan:
1. Reset then free run: rst high 2 cycles, memory words 0x11111111, 0x22222222, 0x33333333 at bytes 0/4/8.
   - Expected: BOOT cycle shows ifid_valid=0 and pc_out=0.
   - Expected: next edges give ifid_instr 0x11111111 (pc_plus4=4), then 0x22222222 (8), then 0x33333333 (12).
2. Stall: assert stall for 3 cycles while pc_out=8.
   - Expected: pc_out stays 8 and ifid_instr stays 0x22222222 for 3 cycles.
   - Expected: after release, 0x33333333 is captured.
3. Redirect with simultaneous stall: redirect_valid=1, target=0x100, stall=1 at pc_out=0x10.
   - Expected: next pc_out=0x100, ifid_valid=0, ifid_instr=0.
   - Expected: following edge ifid_instr=mem[0x100], ifid_pc_plus4=0x104.
4. Misaligned redirect: target=0x0A6.
   - Expected: pc_out=0x0A4, misalign_err=1, and it stays 1 through 10 further cycles until rst.
5. Wrap-around: redirect to 0x3FC, then run.
   - Expected: ifid_pc_plus4=0x000, pc_out=0x000, ifid_instr=mem[0x3FC], misalign_err unchanged.
6. Halt and reset mid-operation: halt_req with redirect_valid=1 at pc_out=0x20.
   - Expected: halted=1, pc_out stays 0x20, ifid_valid=0 for 5 cycles.
   - Expected: rst then gives pc_out=0 and halted=0; rst asserted during an active stall also restores all reset values.
